// File: rtl/level_ctrl_pkg.sv
// Shared state encodings, default timing parameters and counter sizing helper
// for the tank level pump controller.
package level_ctrl_pkg;

    localparam int unsigned TICK_DIV_DEF      = 32'd100000;
    localparam int unsigned CONFIRM_TICKS_DEF = 32'd50;
    localparam int unsigned MIN_RUN_TICKS_DEF = 32'd1000;
    localparam int unsigned MAX_RUN_TICKS_DEF = 32'd60000;
    localparam int unsigned BLINK_TICKS_DEF   = 32'd250;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_LOW_CONFIRM  = 3'd1,
        ST_FILLING      = 3'd2,
        ST_HIGH_CONFIRM = 3'd3,
        ST_DRAINING     = 3'd4,
        ST_FAULT        = 3'd5
    } state_e;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(max_val + 32'd1);
        end
    endfunction

endpackage

// File: rtl/level_pump_controller_checker.sv
// Output invariants of the level pump controller: actuators exclusive and
// consistent with the reported state.
module level_pump_controller_checker (
    input logic       clk_100MHz,
    input logic       reset,
    input logic       pump_on,
    input logic       drain_on,
    input logic       fault,
    input logic [2:0] state_code
);

    a_actuators_exclusive: assert property (@(posedge clk_100MHz) disable iff (reset)
        !(pump_on && drain_on))
        else $error("pump_on and drain_on asserted together");

    a_pump_matches_state: assert property (@(posedge clk_100MHz) disable iff (reset)
        pump_on == (state_code == 3'd2))
        else $error("pump_on disagrees with state_code");

    a_fault_matches_state: assert property (@(posedge clk_100MHz) disable iff (reset)
        fault == (state_code == 3'd5))
        else $error("fault disagrees with state_code");

endmodule

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen
    import level_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk_100MHz,
    input  logic reset,
    output logic tick
);

    localparam int unsigned W = cnt_width(TICK_DIV - 32'd1);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 32'd1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Wrap to zero after the last count of the period.
    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = {W{1'b0}};
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/level_pump_controller.sv
// Tank level controller: confirms threshold flags over a tick timebase, runs the
// fill pump or drain valve with min/max run limits, and latches sensor faults.
module level_pump_controller
    import level_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV      = TICK_DIV_DEF,
    parameter int unsigned CONFIRM_TICKS = CONFIRM_TICKS_DEF,
    parameter int unsigned MIN_RUN_TICKS = MIN_RUN_TICKS_DEF,
    parameter int unsigned MAX_RUN_TICKS = MAX_RUN_TICKS_DEF,
    parameter int unsigned BLINK_TICKS   = BLINK_TICKS_DEF
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       GOET,
    input  logic       LOET,
    input  logic       ack,
    output logic       pump_on,
    output logic       drain_on,
    output logic       alarm_led,
    output logic       fault,
    output logic [2:0] state_code
);

    localparam int unsigned CW = cnt_width(MAX_RUN_TICKS);
    localparam int unsigned BW = cnt_width(BLINK_TICKS);
    localparam logic [CW-1:0] CNT_MAX     = CW'(MAX_RUN_TICKS);
    localparam logic [CW-1:0] CNT_MIN     = CW'(MIN_RUN_TICKS);
    localparam logic [CW-1:0] CNT_CONFIRM = CW'(CONFIRM_TICKS);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_TICKS - 32'd1);

    logic          tick_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_s;
    logic [BW-1:0] blink_q, blink_d;
    logic          alarm_q, alarm_d;
    logic          pump_q, drain_q, fault_q;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .tick       (tick_s)
    );

    // cnt_s is the count as it will be after this edge, so thresholds act on the reaching tick.
    always_comb begin
        if (tick_s && (cnt_q != CNT_MAX)) begin
            cnt_s = cnt_q + CW'(1);
        end else begin
            cnt_s = cnt_q;
        end

        state_d = state_q;
        if (GOET && LOET) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (LOET)      state_d = ST_LOW_CONFIRM;
                    else if (GOET) state_d = ST_HIGH_CONFIRM;
                    else           state_d = ST_IDLE;
                end
                ST_LOW_CONFIRM: begin
                    if (!LOET)                     state_d = ST_IDLE;
                    else if (cnt_s >= CNT_CONFIRM) state_d = ST_FILLING;
                    else                           state_d = ST_LOW_CONFIRM;
                end
                ST_HIGH_CONFIRM: begin
                    if (!GOET)                     state_d = ST_IDLE;
                    else if (cnt_s >= CNT_CONFIRM) state_d = ST_DRAINING;
                    else                           state_d = ST_HIGH_CONFIRM;
                end
                ST_FILLING: begin
                    if (cnt_s == CNT_MAX)                  state_d = ST_FAULT;
                    else if (!LOET && (cnt_s >= CNT_MIN))  state_d = ST_IDLE;
                    else                                   state_d = ST_FILLING;
                end
                ST_DRAINING: begin
                    if (cnt_s == CNT_MAX)                  state_d = ST_FAULT;
                    else if (!GOET && (cnt_s >= CNT_MIN))  state_d = ST_IDLE;
                    else                                   state_d = ST_DRAINING;
                end
                ST_FAULT: begin
                    if (ack && !GOET && !LOET) state_d = ST_IDLE;
                    else                       state_d = ST_FAULT;
                end
                default: state_d = ST_FAULT;
            endcase
        end
    end

    // Tick counter restarts on any state change; alarm blinks only while in FAULT.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_s;
        end

        if (state_d != ST_FAULT) begin
            blink_d = {BW{1'b0}};
            alarm_d = 1'b0;
        end else if (state_q != ST_FAULT) begin
            blink_d = {BW{1'b0}};
            alarm_d = 1'b1;
        end else if (tick_s) begin
            if (blink_q >= BLINK_LAST) begin
                blink_d = {BW{1'b0}};
                alarm_d = !alarm_q;
            end else begin
                blink_d = blink_q + BW'(1);
                alarm_d = alarm_q;
            end
        end else begin
            blink_d = blink_q;
            alarm_d = alarm_q;
        end
    end

    // State, counters and outputs all update together from the next state.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            blink_q <= {BW{1'b0}};
            alarm_q <= 1'b0;
            pump_q  <= 1'b0;
            drain_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
            alarm_q <= alarm_d;
            pump_q  <= (state_d == ST_FILLING);
            drain_q <= (state_d == ST_DRAINING);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign pump_on    = pump_q;
    assign drain_on   = drain_q;
    assign alarm_led  = alarm_q;
    assign fault      = fault_q;
    assign state_code = state_q;

endmodule

// File: tb/tb_level_pump_controller.sv
// Directed self-checking bench for level_pump_controller with short timebase
// (TICK_DIV=4, CONFIRM=3, MIN=5, MAX=20, BLINK=2).
module tb_level_pump_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       GOET;
    logic       LOET;
    logic       ack;
    logic       pump_on;
    logic       drain_on;
    logic       alarm_led;
    logic       fault;
    logic [2:0] state_code;

    int checks   = 0;
    int failures = 0;

    // Expected {state_code, pump_on, drain_on, fault, alarm_led}
    localparam logic [6:0] E_IDLE      = {3'd0, 4'b0000};
    localparam logic [6:0] E_LOWC      = {3'd1, 4'b0000};
    localparam logic [6:0] E_FILL      = {3'd2, 4'b1000};
    localparam logic [6:0] E_HIGHC     = {3'd3, 4'b0000};
    localparam logic [6:0] E_DRAIN     = {3'd4, 4'b0100};
    localparam logic [6:0] E_FAULT_ON  = {3'd5, 4'b0011};
    localparam logic [6:0] E_FAULT_OFF = {3'd5, 4'b0010};

    always #5 clk = ~clk;

    level_pump_controller #(
        .TICK_DIV      (4),
        .CONFIRM_TICKS (3),
        .MIN_RUN_TICKS (5),
        .MAX_RUN_TICKS (20),
        .BLINK_TICKS   (2)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .GOET       (GOET),
        .LOET       (LOET),
        .ack        (ack),
        .pump_on    (pump_on),
        .drain_on   (drain_on),
        .alarm_led  (alarm_led),
        .fault      (fault),
        .state_code (state_code)
    );

    level_pump_controller_checker u_chk (
        .clk_100MHz (clk),
        .reset      (reset),
        .pump_on    (pump_on),
        .drain_on   (drain_on),
        .fault      (fault),
        .state_code (state_code)
    );

    function automatic logic [6:0] outs();
        return {state_code, pump_on, drain_on, fault, alarm_led};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after the reset edge (prescaler at 0).
    task automatic apply_reset();
        reset = 1'b1;
        GOET  = 1'b0;
        LOET  = 1'b0;
        ack   = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    // Actuator exclusion sampled every cycle on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if (pump_on && drain_on) begin
                failures++;
                $display("FAIL exclusive: pump_on=%b drain_on=%b required not both 1", pump_on, drain_on);
            end
        end
    end

    task automatic test_reset();
        apply_reset();
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL reset_state: got %b want %b", outs(), E_IDLE); end
        step(3);
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL idle_hold: got %b want %b", outs(), E_IDLE); end
    endtask

    task automatic test_fill();
        apply_reset();
        LOET = 1'b1;
        step(1);
        checks++;
        if (outs() !== E_LOWC) begin failures++; $display("FAIL fill_lowconf: got %b want %b", outs(), E_LOWC); end
        step(10);
        checks++;
        if (outs() !== E_LOWC) begin failures++; $display("FAIL fill_before_confirm: got %b want %b", outs(), E_LOWC); end
        step(1);
        checks++;
        if (outs() !== E_FILL) begin failures++; $display("FAIL fill_enter: got %b want %b", outs(), E_FILL); end
        step(32);
        checks++;
        if (outs() !== E_FILL) begin failures++; $display("FAIL fill_running: got %b want %b", outs(), E_FILL); end
        LOET = 1'b0;
        step(1);
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL fill_exit: got %b want %b", outs(), E_IDLE); end
    endtask

    task automatic test_abort();
        apply_reset();
        LOET = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checks++;
            if (outs() !== E_LOWC) begin failures++; $display("FAIL abort_confirming cyc%0d: got %b want %b", i, outs(), E_LOWC); end
        end
        LOET = 1'b0;
        step(1);
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL abort_idle: got %b want %b", outs(), E_IDLE); end
        LOET = 1'b1;
        step(1);
        checks++;
        if (outs() !== E_LOWC) begin failures++; $display("FAIL abort_restart: got %b want %b", outs(), E_LOWC); end
        step(9);
        checks++;
        if (outs() !== E_LOWC) begin failures++; $display("FAIL abort_full_confirm: got %b want %b", outs(), E_LOWC); end
        step(1);
        checks++;
        if (outs() !== E_FILL) begin failures++; $display("FAIL abort_refill: got %b want %b", outs(), E_FILL); end
    endtask

    task automatic test_drain_min();
        apply_reset();
        GOET = 1'b1;
        step(1);
        checks++;
        if (outs() !== E_HIGHC) begin failures++; $display("FAIL drain_highconf: got %b want %b", outs(), E_HIGHC); end
        step(11);
        checks++;
        if (outs() !== E_DRAIN) begin failures++; $display("FAIL drain_enter: got %b want %b", outs(), E_DRAIN); end
        step(8);
        GOET = 1'b0;
        step(11);
        checks++;
        if (outs() !== E_DRAIN) begin failures++; $display("FAIL drain_min_hold: got %b want %b", outs(), E_DRAIN); end
        step(1);
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL drain_min_exit: got %b want %b", outs(), E_IDLE); end
    endtask

    task automatic test_timeout();
        apply_reset();
        GOET = 1'b1;
        step(12);
        checks++;
        if (outs() !== E_DRAIN) begin failures++; $display("FAIL timeout_drain: got %b want %b", outs(), E_DRAIN); end
        step(79);
        checks++;
        if (outs() !== E_DRAIN) begin failures++; $display("FAIL timeout_last_drain: got %b want %b", outs(), E_DRAIN); end
        step(1);
        checks++;
        if (outs() !== E_FAULT_ON) begin failures++; $display("FAIL timeout_fault: got %b want %b", outs(), E_FAULT_ON); end
        step(7);
        checks++;
        if (outs() !== E_FAULT_ON) begin failures++; $display("FAIL blink_hold: got %b want %b", outs(), E_FAULT_ON); end
        step(1);
        checks++;
        if (outs() !== E_FAULT_OFF) begin failures++; $display("FAIL blink_toggle1: got %b want %b", outs(), E_FAULT_OFF); end
        step(7);
        checks++;
        if (outs() !== E_FAULT_OFF) begin failures++; $display("FAIL blink_off_hold: got %b want %b", outs(), E_FAULT_OFF); end
        step(1);
        checks++;
        if (outs() !== E_FAULT_ON) begin failures++; $display("FAIL blink_toggle2: got %b want %b", outs(), E_FAULT_ON); end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (outs() !== E_FAULT_ON) begin failures++; $display("FAIL ack_ignored: got %b want %b", outs(), E_FAULT_ON); end
        GOET = 1'b0;
        step(2);
        checks++;
        if (outs() !== E_FAULT_ON) begin failures++; $display("FAIL fault_no_ack: got %b want %b", outs(), E_FAULT_ON); end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL ack_exit: got %b want %b", outs(), E_IDLE); end
    endtask

    task automatic test_illegal();
        apply_reset();
        LOET = 1'b1;
        step(12);
        checks++;
        if (outs() !== E_FILL) begin failures++; $display("FAIL illegal_pre_fill: got %b want %b", outs(), E_FILL); end
        step(2);
        GOET = 1'b1;
        step(1);
        GOET = 1'b0;
        checks++;
        if (outs() !== E_FAULT_ON) begin failures++; $display("FAIL illegal_fault: got %b want %b", outs(), E_FAULT_ON); end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        checks++;
        if (outs() !== E_FAULT_ON) begin failures++; $display("FAIL illegal_ack_ignored: got %b want %b", outs(), E_FAULT_ON); end
        reset = 1'b1;
        LOET  = 1'b0;
        step(1);
        reset = 1'b0;
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL fault_reset: got %b want %b", outs(), E_IDLE); end
    endtask

    task automatic test_reset_filling();
        apply_reset();
        LOET = 1'b1;
        step(12);
        checks++;
        if (outs() !== E_FILL) begin failures++; $display("FAIL rst_pre_fill: got %b want %b", outs(), E_FILL); end
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if (outs() !== E_IDLE) begin failures++; $display("FAIL reset_in_fill: got %b want %b", outs(), E_IDLE); end
        step(1);
        checks++;
        if (outs() !== E_LOWC) begin failures++; $display("FAIL post_reset_restart: got %b want %b", outs(), E_LOWC); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_abort();
        test_drain_min();
        test_timeout();
        test_illegal();
        test_reset_filling();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
